// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M multiply/divide unit.
//   Multiplies with unsigned shift-add and divides with restoring division,
//   both over operand magnitudes. Each CALC cycle resolves STEP result bits.
//   The pipeline is stalled through hold_o while the unit computes. The result
//   is presented with a one-cycle valid_o strobe.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   start, op        request (funct3 encoding), accepted only in IDLE
//   rs1_rdata        multiplicand / dividend
//   rs2_rdata        multiplier / divisor
//   rd_waddr         destination register, captured on accept
//   flush            abort the current operation; also blocks a same-cycle start
//   busy_o           registered, high while not IDLE
//   hold_o           combinational stall request
//   valid_o          one-cycle result strobe
//   rd_waddr_o       destination of the current/last result
//   rd_wdata_o       result, meaningful while valid_o is high
module mdu_iter #(
  parameter int DW   = 32,
  parameter int STEP = 1,
  parameter int RAW  = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2:0]     op,
  input  logic [DW-1:0]  rs1_rdata,
  input  logic [DW-1:0]  rs2_rdata,
  input  logic [RAW-1:0] rd_waddr,
  input  logic           flush,
  output logic           busy_o,
  output logic           hold_o,
  output logic           valid_o,
  output logic [RAW-1:0] rd_waddr_o,
  output logic [DW-1:0]  rd_wdata_o
);

  localparam int NCYC = DW / STEP;
  localparam int CW   = $clog2(NCYC) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(NCYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);
  localparam logic [DW-1:0] MIN_NEG  = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t          state_r;
  logic [2:0]      op_r;
  logic [DW-1:0]   opnd_r;   // multiplicand for MUL*, divisor for DIV*/REM*
  logic [2*DW-1:0] acc_r;    // {high/remainder, low/multiplier/quotient}
  logic [CW-1:0]   cnt_r;
  logic            sign1_r;
  logic            sign2_r;
  logic            busy_r;
  logic            valid_r;

  logic            accept_s;
  logic            sign1_s;
  logic            sign2_s;
  logic [DW-1:0]   mag1_s;
  logic [DW-1:0]   mag2_s;
  logic            div_zero_s;
  logic            div_ovf_s;
  logic            special_s;
  logic [DW-1:0]   special_res_s;
  logic [2*DW:0]   mul_acc_s;
  logic [DW-1:0]   div_hi_s;
  logic [DW-1:0]   div_lo_s;
  logic [DW:0]     trial_s;
  logic [2*DW-1:0] acc_nxt_s;
  logic [2*DW-1:0] prod_s;
  logic [DW-1:0]   quot_s;
  logic [DW-1:0]   rem_s;
  logic [DW-1:0]   final_res_s;

  assign accept_s = (state_r == IDLE) && start && !flush;
  assign hold_o   = accept_s || (state_r == CALC);
  assign busy_o   = busy_r;
  assign valid_o  = valid_r;

  // Operand decode: sign flags, magnitudes and the divide special cases.
  always_comb begin
    // rs1 is signed for MULH, MULHSU, DIV, REM; rs2 is signed for MULH, DIV, REM.
    sign1_s    = rs1_rdata[DW-1] &&
                 ((op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110));
    sign2_s    = rs2_rdata[DW-1] &&
                 ((op == 3'b001) || (op == 3'b100) || (op == 3'b110));
    mag1_s     = sign1_s ? -rs1_rdata : rs1_rdata;
    mag2_s     = sign2_s ? -rs2_rdata : rs2_rdata;
    div_zero_s = (rs2_rdata == {DW{1'b0}});
    div_ovf_s  = !op[0] && (rs1_rdata == MIN_NEG) && (rs2_rdata == {DW{1'b1}});
    special_s  = op[2] && (div_zero_s || div_ovf_s);
    if (div_zero_s) begin
      special_res_s = op[1] ? rs1_rdata : {DW{1'b1}};
    end else begin
      special_res_s = op[1] ? {DW{1'b0}} : rs1_rdata;
    end
  end

  // STEP iterations of shift-add (multiply) or restoring division per cycle.
  always_comb begin
    mul_acc_s = {1'b0, acc_r};
    div_hi_s  = acc_r[2*DW-1:DW];
    div_lo_s  = acc_r[DW-1:0];
    trial_s   = {(DW+1){1'b0}};
    for (int i = 0; i < STEP; i++) begin
      // Carry of the partial-product add lands in the extra top bit before the shift.
      if (mul_acc_s[0]) begin
        mul_acc_s[2*DW:DW] = mul_acc_s[2*DW:DW] + {1'b0, opnd_r};
      end else begin
        mul_acc_s = mul_acc_s;
      end
      mul_acc_s = mul_acc_s >> 1;
      // A set top bit of the trial difference means a borrow, so restore.
      trial_s = {div_hi_s, div_lo_s[DW-1]} - {1'b0, opnd_r};
      if (!trial_s[DW]) begin
        div_hi_s = trial_s[DW-1:0];
        div_lo_s = {div_lo_s[DW-2:0], 1'b1};
      end else begin
        div_hi_s = {div_hi_s[DW-2:0], div_lo_s[DW-1]};
        div_lo_s = {div_lo_s[DW-2:0], 1'b0};
      end
    end
    if (op_r[2]) begin
      acc_nxt_s = {div_hi_s, div_lo_s};
    end else begin
      acc_nxt_s = mul_acc_s[2*DW-1:0];
    end
  end

  // Sign correction and selection of the final result from the last iteration.
  always_comb begin
    prod_s = (sign1_r ^ sign2_r) ? -acc_nxt_s : acc_nxt_s;
    quot_s = (sign1_r ^ sign2_r) ? -acc_nxt_s[DW-1:0] : acc_nxt_s[DW-1:0];
    rem_s  = sign1_r ? -acc_nxt_s[2*DW-1:DW] : acc_nxt_s[2*DW-1:DW];
    if (op_r[2]) begin
      final_res_s = op_r[1] ? rem_s : quot_s;
    end else if (op_r[1:0] == 2'b00) begin
      final_res_s = prod_s[DW-1:0];
    end else begin
      final_res_s = prod_s[2*DW-1:DW];
    end
  end

  // Control FSM with operand capture, iteration state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      op_r       <= 3'b000;
      opnd_r     <= {DW{1'b0}};
      acc_r      <= {(2*DW){1'b0}};
      cnt_r      <= {CW{1'b0}};
      sign1_r    <= 1'b0;
      sign2_r    <= 1'b0;
      busy_r     <= 1'b0;
      valid_r    <= 1'b0;
      rd_waddr_o <= {RAW{1'b0}};
      rd_wdata_o <= {DW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            op_r       <= op;
            rd_waddr_o <= rd_waddr;
            sign1_r    <= sign1_s;
            sign2_r    <= sign2_s;
            cnt_r      <= CNT_LOAD;
            busy_r     <= 1'b1;
            // Divisor goes to opnd_r; dividend shifts out of the low half.
            opnd_r     <= op[2] ? mag2_s : mag1_s;
            acc_r      <= {{DW{1'b0}}, (op[2] ? mag1_s : mag2_s)};
            if (special_s) begin
              state_r    <= DONE;
              valid_r    <= 1'b1;
              rd_wdata_o <= special_res_s;
            end else begin
              state_r    <= CALC;
              valid_r    <= 1'b0;
            end
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
          end
        end
        CALC: begin
          if (flush) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
          end else begin
            acc_r <= acc_nxt_s;
            cnt_r <= cnt_r - CNT_LAST;
            if (cnt_r == CNT_LAST) begin
              state_r    <= DONE;
              valid_r    <= 1'b1;
              rd_wdata_o <= final_res_s;
            end else begin
              state_r <= CALC;
              valid_r <= 1'b0;
            end
          end
        end
        DONE: begin
          // The strobe lasts exactly this cycle, even if flush is asserted.
          state_r <= IDLE;
          busy_r  <= 1'b0;
          valid_r <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Testbench for mdu_iter: one STEP=1 instance and one STEP=4 instance.
// The expected {rd, data} is queued when an operation is issued. It is popped
// and compared when valid_o appears.
module tb_mdu_iter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // STEP=1 instance signals
  logic        rst, start, flush;
  logic [2:0]  op;
  logic [31:0] rs1, rs2;
  logic [4:0]  rd;
  logic        busy, hold, valid;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  // STEP=4 instance signals
  logic        rst4, start4, flush4;
  logic [2:0]  op4;
  logic [31:0] a4, b4;
  logic [4:0]  rd4;
  logic        busy4, hold4, valid4;
  logic [4:0]  waddr4;
  logic [31:0] wdata4;

  int n_assert = 0;
  int n_fail   = 0;
  logic [36:0] sb_q[$];

  mdu_iter #(.DW(32), .STEP(1), .RAW(5)) u_dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs1_rdata(rs1), .rs2_rdata(rs2),
    .rd_waddr(rd), .flush(flush), .busy_o(busy), .hold_o(hold), .valid_o(valid),
    .rd_waddr_o(waddr), .rd_wdata_o(wdata));

  mdu_iter #(.DW(32), .STEP(4), .RAW(5)) u_dut4 (
    .clk(clk), .rst(rst4), .start(start4), .op(op4), .rs1_rdata(a4), .rs2_rdata(b4),
    .rd_waddr(rd4), .flush(flush4), .busy_o(busy4), .hold_o(hold4), .valid_o(valid4),
    .rd_waddr_o(waddr4), .rd_wdata_o(wdata4));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one op on the STEP=1 instance from cycle 0 and follow it to writeback.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] r,
                        input logic [31:0] exp, input int lat);
    logic [36:0] e;
    int n;
    logic stall_ok;
    sb_q.push_back({r, exp});
    op = o; rs1 = a; rs2 = b; rd = r; start = 1'b1;
    #1;
    check({tag, " hold_accept"}, 64'(hold), 64'(1));
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    stall_ok = 1'b1;
    while (valid !== 1'b1 && n < 200) begin
      if (hold !== 1'b1 || busy !== 1'b1) stall_ok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'(lat));
    check({tag, " hold_busy_calc"}, 64'(stall_ok), 64'(1));
    check({tag, " hold_done"}, 64'(hold), 64'(0));
    check({tag, " busy_done"}, 64'(busy), 64'(1));
    e = sb_q.pop_front();
    check({tag, " data"}, 64'(wdata), 64'(e[31:0]));
    check({tag, " rd"}, 64'(waddr), 64'(e[36:32]));
    @(posedge clk); #1;
    check({tag, " valid_after"}, 64'(valid), 64'(0));
    check({tag, " busy_after"}, 64'(busy), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [36:0] e4;
    int n;
    logic saw_v;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'b000; rs1 = 32'h0; rs2 = 32'h0; rd = 5'd0;
    rst4 = 1'b1; start4 = 1'b0; flush4 = 1'b0; op4 = 3'b000; a4 = 32'h0; b4 = 32'h0; rd4 = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst busy", 64'(busy), 64'(0));
    check("rst valid", 64'(valid), 64'(0));
    check("rst waddr", 64'(waddr), 64'(0));
    check("rst wdata", 64'(wdata), 64'(0));
    check("rst hold", 64'(hold), 64'(0));
    check("rst4 busy", 64'(busy4), 64'(0));
    rst = 1'b0; rst4 = 1'b0;
    @(posedge clk); #1;

    // Multiply variants
    run_op("mul_neg3",  3'b000, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 33);
    run_op("mulh",      3'b001, 32'h80000000, 32'h80000000, 5'd6,  32'h40000000, 33);
    run_op("mulhu",     3'b011, 32'h80000000, 32'h80000000, 5'd7,  32'h40000000, 33);
    run_op("mulhsu",    3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFF, 33);
    // Divide variants
    run_op("div_m7_2",  3'b100, 32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFD, 33);
    run_op("rem_m7_2",  3'b110, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFF, 33);
    run_op("divu",      3'b101, 32'd100,      32'd7,        5'd11, 32'd14,       33);
    run_op("remu",      3'b111, 32'd100,      32'd7,        5'd12, 32'd2,        33);
    // Special-case divides complete in cycle 1
    run_op("divu_zero", 3'b101, 32'h1234,     32'h0,        5'd13, 32'hFFFFFFFF, 1);
    run_op("rem_zero",  3'b110, 32'h1234,     32'h0,        5'd14, 32'h1234,     1);
    run_op("div_ovf",   3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 1);
    run_op("rem_ovf",   3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h0,        1);

    // Flush in IDLE blocks a same-cycle start
    op = 3'b000; rs1 = 32'd2; rs2 = 32'd2; rd = 5'd20; start = 1'b1; flush = 1'b1;
    #1;
    check("idle_flush hold", 64'(hold), 64'(0));
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("idle_flush busy", 64'(busy), 64'(0));
    check("idle_flush waddr", 64'(waddr), 64'(16));

    // DIV flushed at cycle 10; a start at cycle 5 (CALC) must be ignored
    op = 3'b100; rs1 = 32'd100; rs2 = 32'd7; rd = 5'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    saw_v = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (c == 5) begin
        start = 1'b1; op = 3'b000; rd = 5'd9;
      end else begin
        start = 1'b0;
      end
      flush = (c == 10);
      if (valid === 1'b1) saw_v = 1'b1;
      @(posedge clk); #1;
    end
    start = 1'b0; flush = 1'b0;
    check("flush busy_c11", 64'(busy), 64'(0));
    check("flush no_valid", 64'(saw_v | valid), 64'(0));
    check("calc_start ignored rd", 64'(waddr), 64'(3));
    run_op("mul_after_flush", 3'b000, 32'd3, 32'd4, 5'd7, 32'd12, 33);

    // STEP=4: MUL 0xFFFF x 0xFFFF completes in cycle 9
    sb_q.push_back({5'd2, 32'hFFFE0001});
    op4 = 3'b000; a4 = 32'h0000FFFF; b4 = 32'h0000FFFF; rd4 = 5'd2; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    n = 1;
    while (valid4 !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("step4 latency", 64'(n), 64'(9));
    e4 = sb_q.pop_front();
    check("step4 data", 64'(wdata4), 64'(e4[31:0]));
    check("step4 rd", 64'(waddr4), 64'(e4[36:32]));
    @(posedge clk); #1;

    // STEP=4: reset during CALC cycle 5 clears everything, no strobe
    op4 = 3'b000; a4 = 32'h1234; b4 = 32'h5678; rd4 = 5'd6; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("step4 busy_before_rst", 64'(busy4), 64'(1));
    rst4 = 1'b1;
    @(posedge clk); #1;
    check("rst_calc busy", 64'(busy4), 64'(0));
    check("rst_calc valid", 64'(valid4), 64'(0));
    check("rst_calc waddr", 64'(waddr4), 64'(0));
    check("rst_calc wdata", 64'(wdata4), 64'(0));
    check("rst_calc hold", 64'(hold4), 64'(0));
    rst4 = 1'b0;
    saw_v = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (valid4 === 1'b1) saw_v = 1'b1;
    end
    check("rst_calc no_valid", 64'(saw_v), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
